test_monitor: RTL and testbench

TEST_MONITOR -- requirements
Module: test_monitor

---
 rtl/test_monitor.sv | 121 ++++++++++++
 tb/tb_test_monitor.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_monitor.sv
// Simulation test monitor. It watches the core's data-memory store port for
// writes to the tohost word and turns them into a PASS / FAIL / TMO verdict.
// It also counts cycles and retired instructions for the current run.
// The FSM state is exported directly on `state` so that checkers can observe it.
// There is no valid/ready handshake in this block. A store counts only in a
// cycle where wr_en=1, and it is sampled on the rising edge of clk.
module test_monitor #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_1000,
  parameter int unsigned     TIMEOUT     = 5000,
  parameter int              CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             wr_en,
  input  logic [XLEN-1:0]  wr_addr,
  input  logic [XLEN-1:0]  wr_data,
  input  logic             retire,
  output logic [2:0]       state,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [XLEN-2:0]  test_id,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_PASS = 3'd2,
    S_FAIL = 3'd3,
    S_TMO  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [XLEN-1:0]  PASS_CODE = XLEN'(1);
  // This is the value of the cycle count on the last RUN edge. It is only used
  // when TIMEOUT != 0.
  localparam logic [63:0]      TMO_LAST  = 64'(TIMEOUT) - 64'd1;

  state_t           state_q, state_d;
  logic [XLEN-2:0]  tid_q, tid_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ins_q, ins_d;
  logic             hit;
  logic             tmo_due;

  // A tohost hit counts only while running. Stores at any other time are ignored.
  assign hit = (state_q == S_RUN) && wr_en && (wr_addr == TOHOST_ADDR);

  // The comparison uses >= rather than ==. A hit with an even value can hold off
  // the timeout on its due edge, and the timeout then fires on the next edge.
  assign tmo_due = (TIMEOUT != 0) && (64'(cyc_q) >= TMO_LAST);

  // This block holds the state, counters and failing test id. Reset is
  // asynchronous and active-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tid_q   <= '0;
      cyc_q   <= '0;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      tid_q   <= tid_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
    end
  end

  // This block computes the next state and counter values. By default every
  // value holds.
  always_comb begin
    state_d = state_q;
    tid_d   = tid_q;
    cyc_d   = cyc_q;
    ins_d   = ins_q;
    case (state_q)
      S_RUN: begin
        // The counters also advance on the edge that leaves RUN.
        // They saturate instead of wrapping.
        if (cyc_q != CNT_MAX) cyc_d = cyc_q + CNT_ONE;
        if (retire && (ins_q != CNT_MAX)) ins_d = ins_q + CNT_ONE;
        if (hit && (wr_data == PASS_CODE)) begin
          state_d = S_PASS;
        end else if (hit && wr_data[0]) begin
          state_d = S_FAIL;
          tid_d   = wr_data[XLEN-1:1];
        end else if (!hit && tmo_due) begin
          state_d = S_TMO;
        end
      end
      S_IDLE, S_PASS, S_FAIL, S_TMO: begin
        // In IDLE or any terminal state, start clears the run and arms the monitor.
        if (start) begin
          state_d = S_RUN;
          tid_d   = '0;
          cyc_d   = '0;
          ins_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All outputs are decoded from the registers only, so no input drives an
  // output through combinational logic.
  assign state   = state_q;
  assign pass    = (state_q == S_PASS);
  assign fail    = (state_q == S_FAIL);
  assign timeout = (state_q == S_TMO);
  assign done    = pass | fail | timeout;
  assign test_id = tid_q;
  assign cycles  = cyc_q;
  assign instret = ins_q;

endmodule

// File: tb/tb_test_monitor.sv
// Bench for test_monitor. Two instances share all inputs.
//   dut_a: TIMEOUT=20, CNT_W=32
//   dut_b: TIMEOUT=0,  CNT_W=4 (saturation)
// A behavioural model of each instance is stepped on every edge and compared
// against its DUT. The directed sequences also compare against fixed values.
module tb_test_monitor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, wr_en, retire;
  logic [31:0] wr_addr, wr_data;

  logic [2:0]  a_state, b_state;
  logic        a_done, a_pass, a_fail, a_tmo;
  logic        b_done, b_pass, b_fail, b_tmo;
  logic [30:0] a_tid, b_tid;
  logic [31:0] a_cyc, a_ins;
  logic [3:0]  b_cyc, b_ins;

  test_monitor #(.XLEN(32), .TOHOST_ADDR(32'h0000_1000), .TIMEOUT(20), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .retire(retire), .state(a_state), .done(a_done),
    .pass(a_pass), .fail(a_fail), .timeout(a_tmo), .test_id(a_tid),
    .cycles(a_cyc), .instret(a_ins)
  );

  test_monitor #(.XLEN(32), .TOHOST_ADDR(32'h0000_1000), .TIMEOUT(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .retire(retire), .state(b_state), .done(b_done),
    .pass(b_pass), .fail(b_fail), .timeout(b_tmo), .test_id(b_tid),
    .cycles(b_cyc), .instret(b_ins)
  );

  // ---------------- reference model ----------------
  // st: 0 idle, 1 run, 2 pass, 3 fail, 4 timeout.
  typedef struct {
    int              st;
    longint unsigned cyc;
    longint unsigned ins;
    logic [30:0]     tid;
  } mdl_t;

  mdl_t ma, mb;
  int   errors = 0;
  int   checks = 0;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.st = 0; m.cyc = 0; m.ins = 0; m.tid = '0;
    return m;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, int tmo, longint unsigned cmax);
    mdl_t n = m;
    logic hit;
    hit = (m.st == 1) && wr_en && (wr_addr == 32'h0000_1000);
    if (m.st == 1) begin
      n.cyc = (m.cyc < cmax) ? m.cyc + 1 : cmax;
      if (retire) n.ins = (m.ins < cmax) ? m.ins + 1 : cmax;
      if (hit && wr_data == 32'd1) n.st = 2;
      else if (hit && wr_data[0]) begin
        n.st  = 3;
        n.tid = wr_data[31:1];
      end else if (!hit && tmo != 0 && (m.cyc + 1) >= longint'(tmo)) n.st = 4;
    end else if (start) begin
      n.st = 1; n.cyc = 0; n.ins = 0; n.tid = '0;
    end
    return n;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_models(input string tag);
    chk({tag, ".a.state"},   64'(a_state), 64'(ma.st));
    chk({tag, ".a.done"},    64'(a_done),  64'(ma.st >= 2));
    chk({tag, ".a.pass"},    64'(a_pass),  64'(ma.st == 2));
    chk({tag, ".a.fail"},    64'(a_fail),  64'(ma.st == 3));
    chk({tag, ".a.timeout"}, 64'(a_tmo),   64'(ma.st == 4));
    chk({tag, ".a.test_id"}, 64'(a_tid),   64'(ma.tid));
    chk({tag, ".a.cycles"},  64'(a_cyc),   ma.cyc);
    chk({tag, ".a.instret"}, 64'(a_ins),   ma.ins);
    chk({tag, ".b.state"},   64'(b_state), 64'(mb.st));
    chk({tag, ".b.done"},    64'(b_done),  64'(mb.st >= 2));
    chk({tag, ".b.pass"},    64'(b_pass),  64'(mb.st == 2));
    chk({tag, ".b.fail"},    64'(b_fail),  64'(mb.st == 3));
    chk({tag, ".b.timeout"}, 64'(b_tmo),   64'(mb.st == 4));
    chk({tag, ".b.test_id"}, 64'(b_tid),   64'(mb.tid));
    chk({tag, ".b.cycles"},  64'(b_cyc),   mb.cyc);
    chk({tag, ".b.instret"}, 64'(b_ins),   mb.ins);
  endtask

  // Both instances must read all zeros while in reset.
  task automatic chk_zero(input string tag);
    chk({tag, ".a.state"}, 64'(a_state), 64'd0);
    chk({tag, ".a.flags"}, 64'({a_done, a_pass, a_fail, a_tmo}), 64'd0);
    chk({tag, ".a.tid"},   64'(a_tid), 64'd0);
    chk({tag, ".a.cyc"},   64'(a_cyc), 64'd0);
    chk({tag, ".a.ins"},   64'(a_ins), 64'd0);
    chk({tag, ".b.state"}, 64'(b_state), 64'd0);
    chk({tag, ".b.flags"}, 64'({b_done, b_pass, b_fail, b_tmo}), 64'd0);
    chk({tag, ".b.cyc"},   64'(b_cyc), 64'd0);
    chk({tag, ".b.ins"},   64'(b_ins), 64'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_in();
    start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; retire = 1'b0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
  endtask

  // The models step with the inputs present at the edge. The outputs are then
  // checked 1 ns after the edge. The caller may change inputs only after this
  // task returns.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) begin
      ma = mdl_next(ma, 20, 64'hFFFF_FFFF);
      mb = mdl_next(mb, 0, 64'd15);
    end else begin
      ma = mdl_reset();
      mb = mdl_reset();
    end
    #1;
    chk_models(tag);
  endtask

  // ---------------- table of vectors ----------------
  typedef struct {
    logic        st;
    logic        we;
    logic [31:0] ad;
    logic [31:0] dt;
    logic        rt;
    int          e_st;
    int          e_cyc;
    int          e_ins;
    logic [30:0] e_tid;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // The first row re-arms the monitor from PASS. The table covers a FAIL
    // verdict, a terminal hold, a second re-arm, ignored even values and other
    // addresses, start ignored while in RUN, and a pass on a retire edge.
    tbl[0]  = '{1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 1, 0, 0, 31'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_0007, 1'b0, 3, 1, 0, 31'h3};
    tbl[2]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_0001, 1'b0, 3, 1, 0, 31'h3};
    tbl[3]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_0005, 1'b0, 3, 1, 0, 31'h3};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 1, 0, 0, 31'h0};
    tbl[5]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_0000, 1'b0, 1, 1, 0, 31'h0};
    tbl[6]  = '{1'b0, 1'b1, 32'h0000_1004, 32'h0000_0003, 1'b0, 1, 2, 0, 31'h0};
    tbl[7]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h8000_0001, 1'b0, 3, 3, 0, 31'h4000_0000};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 3, 3, 0, 31'h4000_0000};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 1, 0, 0, 31'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 1, 1, 1, 31'h0};
    tbl[11] = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_0001, 1'b1, 2, 2, 2, 31'h0};
  end

  // ---------------- test sequence ----------------
  initial begin
    int sel;
    rst = 1'b0;
    idle_in();
    ma = mdl_reset();
    mb = mdl_reset();
    #2;
    chk_zero("por");
    tick("por_hold");
    rst = 1'b1;
    tick("idle");

    // Pass after 12 run cycles with 10 retires.
    start = 1'b1;
    tick("r36_arm");
    idle_in();
    chk("r36.arm_state", 64'(a_state), 64'd1);
    chk("r36.arm_cyc",   64'(a_cyc),   64'd0);
    for (int i = 1; i <= 12; i++) begin
      retire = (i <= 10);
      if (i == 12) store(32'h0000_1000, 32'd1);
      tick("r36_run");
      idle_in();
    end
    chk("r36.state", 64'(a_state), 64'd2);
    chk("r36.pass",  64'(a_pass),  64'd1);
    chk("r36.cyc",   64'(a_cyc),   64'd12);
    chk("r36.ins",   64'(a_ins),   64'd10);

    // Apply the table of vectors.
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].st; retire = tbl[i].rt;
      wr_en = tbl[i].we; wr_addr = tbl[i].ad; wr_data = tbl[i].dt;
      tick("tbl");
      idle_in();
      chk($sformatf("tbl%0d.state", i), 64'(a_state), 64'(tbl[i].e_st));
      chk($sformatf("tbl%0d.flags", i), 64'({a_done, a_pass, a_fail, a_tmo}),
          64'({tbl[i].e_st >= 2, tbl[i].e_st == 2, tbl[i].e_st == 3, tbl[i].e_st == 4}));
      chk($sformatf("tbl%0d.cyc", i), 64'(a_cyc), 64'(tbl[i].e_cyc));
      chk($sformatf("tbl%0d.ins", i), 64'(a_ins), 64'(tbl[i].e_ins));
      chk($sformatf("tbl%0d.tid", i), 64'(a_tid), 64'(tbl[i].e_tid));
    end

    // Timeout after exactly 20 cycles.
    start = 1'b1;
    tick("r38_arm");
    idle_in();
    for (int i = 1; i <= 19; i++) tick("r38_run");
    chk("r38.edge19_state", 64'(a_state), 64'd1);
    chk("r38.edge19_cyc",   64'(a_cyc),   64'd19);
    tick("r38_tmo");
    chk("r38.state",   64'(a_state), 64'd4);
    chk("r38.timeout", 64'(a_tmo),   64'd1);
    chk("r38.pass",    64'(a_pass),  64'd0);
    chk("r38.cyc",     64'(a_cyc),   64'd20);
    store(32'h0000_1000, 32'd1);
    tick("r38_hold");
    idle_in();
    chk("r38.hold_state", 64'(a_state), 64'd4);
    // A pass store on the timeout edge wins over the timeout.
    start = 1'b1;
    tick("r38b_arm");
    idle_in();
    for (int i = 1; i <= 19; i++) tick("r38b_run");
    store(32'h0000_1000, 32'd1);
    tick("r38b_hit");
    idle_in();
    chk("r38b.state",   64'(a_state), 64'd2);
    chk("r38b.pass",    64'(a_pass),  64'd1);
    chk("r38b.timeout", 64'(a_tmo),   64'd0);
    chk("r38b.cyc",     64'(a_cyc),   64'd20);

    // Only an odd value written to the tohost address ends the run.
    start = 1'b1;
    tick("r39_arm");
    idle_in();
    store(32'h0000_1000, 32'd2);
    tick("r39_even");
    chk("r39.even_state", 64'(a_state), 64'd1);
    store(32'h0000_1004, 32'd1);
    tick("r39_other");
    chk("r39.other_state", 64'(a_state), 64'd1);
    store(32'h0000_1000, 32'd1);
    tick("r39_pass");
    idle_in();
    chk("r39.state", 64'(a_state), 64'd2);
    chk("r39.pass",  64'(a_pass),  64'd1);

    // Saturation at 4 bits in the no-timeout instance.
    start = 1'b1;
    tick("r41_arm");
    idle_in();
    retire = 1'b1;
    for (int i = 1; i <= 20; i++) tick("r41_run");
    chk("r41.b_state", 64'(b_state), 64'd1);
    chk("r41.b_cyc",   64'(b_cyc),   64'd15);
    chk("r41.b_ins",   64'(b_ins),   64'd15);
    store(32'h0000_1000, 32'd1);
    tick("r41_pass");
    idle_in();
    chk("r41.b_pass",     64'(b_pass), 64'd1);
    chk("r41.b_cyc_sat",  64'(b_cyc),  64'd15);
    chk("r41.b_ins_sat",  64'(b_ins),  64'd15);
    start = 1'b1;
    tick("r41_rearm");
    idle_in();
    chk("r41.rearm_state", 64'(b_state), 64'd1);
    chk("r41.rearm_cyc",   64'(b_cyc),   64'd0);
    chk("r41.rearm_ins",   64'(b_ins),   64'd0);

    // Asynchronous reset in the middle of a run.
    retire = 1'b1;
    for (int i = 0; i < 3; i++) tick("r40_run");
    #3 rst = 1'b0;
    #1;
    ma = mdl_reset();
    mb = mdl_reset();
    chk_zero("r40_async");
    start = 1'b1;
    store(32'h0000_1000, 32'd1);
    tick("r40_held");
    chk_zero("r40_held");
    #3 rst = 1'b1;
    idle_in();
    store(32'h0000_1000, 32'd1);
    for (int i = 0; i < 3; i++) tick("r40_nostart");
    idle_in();
    chk("r40.idle_a", 64'(a_state), 64'd0);
    chk("r40.idle_b", 64'(b_state), 64'd0);

    // Random stimulus checked against the models.
    for (int n = 0; n < 1500; n++) begin
      start  = ($urandom_range(0, 24) == 0);
      retire = $urandom_range(0, 1);
      wr_en  = ($urandom_range(0, 9) < 3);
      sel = $urandom_range(0, 9);
      wr_addr = (sel < 6) ? 32'h0000_1000 : (sel < 8) ? 32'h0000_1004 : $urandom;
      sel = $urandom_range(0, 4);
      case (sel)
        0: wr_data = 32'd1;
        1: wr_data = 32'd0;
        2: wr_data = {$urandom_range(0, 32'h7FFF_FFFF), 1'b0};
        3: wr_data = $urandom | 32'd1;
        default: wr_data = $urandom;
      endcase
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b0;
        #1;
        ma = mdl_reset();
        mb = mdl_reset();
        chk_models("rnd_rst");
        #1 rst = 1'b1;
      end
      tick("rnd");
    end
    idle_in();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
